// File: rtl/data_ram_param_if.sv
// rtl/data_ram_param_if.sv - request/response bundle between the data RAM and its users
interface data_ram_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic                ctrl_write;
    logic [ADDR_W-1:0]   i_addr_write;
    logic [DATA_W-1:0]   i_data_write;
    logic [DATA_W/8-1:0] i_wr_be;
    logic                ctrl_read;
    logic [ADDR_W-1:0]   i_addr_read;
    logic [DATA_W-1:0]   o_data_read;
    logic                o_rd_valid;
    logic                ctrl_clear;
    logic                o_busy;

    modport master (
        output ctrl_write, i_addr_write, i_data_write, i_wr_be,
        output ctrl_read, i_addr_read, ctrl_clear,
        input  o_data_read, o_rd_valid, o_busy
    );

    modport slave (
        input  ctrl_write, i_addr_write, i_data_write, i_wr_be,
        input  ctrl_read, i_addr_read, ctrl_clear,
        output o_data_read, o_rd_valid, o_busy
    );
endinterface

// File: rtl/data_ram_param.sv
// rtl/data_ram_param.sv - parametrised data RAM: byte lanes, 1/2-cycle read pipeline, write-first bypass, clear sequencer
// Optional: DATA_RAM_CLR_ON_RST_EN makes reset start a zero-fill sweep.
module data_ram_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 1 << ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    data_ram_param_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

`ifdef DATA_RAM_CLR_ON_RST_EN
    localparam state_t RST_STATE = ST_CLEAR;
`else
    localparam state_t RST_STATE = ST_IDLE;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_addr_q, clr_addr_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic              wr_in_range, rd_in_range, collide, rd_acc;
    logic [IDX_W-1:0]  widx, ridx;
    logic [DATA_W-1:0] wr_merged, rd_word;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdata;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    // Merged write word doubles as the write-first bypass value on a same-address collision.
    always_comb begin
        wr_in_range = in_range(bus.i_addr_write);
        rd_in_range = in_range(bus.i_addr_read);
        widx        = bus.i_addr_write[IDX_W-1:0];
        ridx        = bus.i_addr_read[IDX_W-1:0];
        wr_merged   = wr_in_range ? mem[widx] : '0;
        for (int k = 0; k < BE_W; k++) begin
            if (bus.i_wr_be[k]) begin
                wr_merged[8*k +: 8] = bus.i_data_write[8*k +: 8];
            end
        end
        collide = bus.ctrl_write && (bus.i_addr_write == bus.i_addr_read);
        if (!rd_in_range) begin
            rd_word = '0;
        end else if (collide) begin
            rd_word = wr_merged;
        end else begin
            rd_word = mem[ridx];
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        rd_acc     = 1'b0;
        mem_we     = 1'b0;
        mem_widx   = widx;
        mem_wdata  = wr_merged;
        case (state_q)
            ST_IDLE: begin
                if (bus.ctrl_clear) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else begin
                    rd_acc = bus.ctrl_read;
                    mem_we = bus.ctrl_write && wr_in_range && (|bus.i_wr_be);
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_widx  = clr_addr_q;
                mem_wdata = '0;
                if (clr_addr_q == LAST_IDX) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + IDX_W'(1);
                end
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // Reset aborts any write in flight; array contents otherwise survive reset.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              pipe_valid_q, pipe_valid_d;
            logic [DATA_W-1:0] pipe_data_q, pipe_data_d;

            always_comb begin
                pipe_valid_d = rd_acc;
                pipe_data_d  = rd_acc ? rd_word : pipe_data_q;
            end

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    pipe_valid_q <= 1'b0;
                    pipe_data_q  <= '0;
                end else begin
                    pipe_valid_q <= pipe_valid_d;
                    pipe_data_q  <= pipe_data_d;
                end
            end

            assign src_valid = pipe_valid_q;
            assign src_data  = pipe_data_q;
        end else begin : g_lat1
            assign src_valid = rd_acc;
            assign src_data  = rd_word;
        end
    endgenerate

    always_comb begin
        rd_valid_d = src_valid;
        rd_data_d  = src_valid ? src_data : rd_data_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= RST_STATE;
            clr_addr_q <= '0;
            busy_q     <= (RST_STATE == ST_CLEAR);
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.o_data_read = rd_data_q;
    assign bus.o_rd_valid  = rd_valid_q;
    assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_data_ram_param.sv
// tb/tb_data_ram_param.sv - randomized bench for data_ram_param, one-cycle and two-cycle read latency instances
module tb_data_ram_param;
    localparam int N = 256;
`ifdef DATA_RAM_CLR_ON_RST_EN
    localparam bit CLR_ON_RST = 1'b1;
`else
    localparam bit CLR_ON_RST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        wr, rd, clr;
    logic [7:0]  wa, ra;
    logic [15:0] wd;
    logic [1:0]  be;

    data_ram_param_if #(.DATA_W(16), .ADDR_W(8)) b1 ();
    data_ram_param_if #(.DATA_W(16), .ADDR_W(8)) b2 ();

    assign b1.ctrl_write = wr;  assign b2.ctrl_write = wr;
    assign b1.i_addr_write = wa; assign b2.i_addr_write = wa;
    assign b1.i_data_write = wd; assign b2.i_data_write = wd;
    assign b1.i_wr_be = be;     assign b2.i_wr_be = be;
    assign b1.ctrl_read = rd;   assign b2.ctrl_read = rd;
    assign b1.i_addr_read = ra; assign b2.i_addr_read = ra;
    assign b1.ctrl_clear = clr; assign b2.ctrl_clear = clr;

    data_ram_param #(.DATA_W(16), .ADDR_W(8), .DEPTH(N), .RD_LAT(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b1));
    data_ram_param #(.DATA_W(16), .ADDR_W(8), .DEPTH(N), .RD_LAT(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b2));

    int total = 0;
    int bad = 0;

    task automatic cmp1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word array, remaining-clear-cycles counter, one-deep delay slot for the 2-cycle instance.
    logic [15:0] m [N];
    int          clr_left = 0;
    int          clr_ptr = 0;
    logic        slot_v = 1'b0;
    logic [15:0] slot_d = '0;
    logic        exp_v1 = 1'b0, exp_v2 = 1'b0, exp_busy = 1'b0;
    logic [15:0] exp_d1 = '0, exp_d2 = '0;

    initial begin
        for (int i = 0; i < N; i++) m[i] = 'x;
    end

    always @(posedge clk) begin : model
        logic [15:0] neww, word;
        logic        take;
        if (!rst_n) begin
            exp_v1 = 1'b0; exp_v2 = 1'b0; exp_d1 = '0; exp_d2 = '0;
            slot_v = 1'b0; slot_d = '0;
            clr_ptr = 0;
            clr_left = CLR_ON_RST ? N : 0;
        end else if (clr_left > 0) begin
            m[clr_ptr] = '0;
            clr_ptr++;
            clr_left--;
            exp_v1 = 1'b0;
            exp_v2 = slot_v;
            if (slot_v) exp_d2 = slot_d;
            slot_v = 1'b0;
        end else begin
            neww = m[wa];
            for (int k = 0; k < 2; k++) if (be[k]) neww[8*k +: 8] = wd[8*k +: 8];
            word = (wr && wa == ra) ? neww : m[ra];
            take = rd && !clr;
            if (wr && !clr) m[wa] = neww;
            exp_v1 = take;
            if (take) exp_d1 = word;
            exp_v2 = slot_v;
            if (slot_v) exp_d2 = slot_d;
            slot_v = take;
            slot_d = word;
            if (clr) begin
                clr_left = N;
                clr_ptr = 0;
            end
        end
        exp_busy = (clr_left > 0);
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            cmp1("busy1", b1.o_busy, exp_busy);
            cmp1("busy2", b2.o_busy, exp_busy);
            cmp1("valid1", b1.o_rd_valid, exp_v1);
            cmp1("valid2", b2.o_rd_valid, exp_v2);
            if (!$isunknown(exp_d1)) cmp16("data1", b1.o_data_read, exp_d1);
            if (!$isunknown(exp_d2)) cmp16("data2", b2.o_data_read, exp_d2);
        end
    end

    task automatic drive(input logic w, input logic [7:0] a_w, input logic [15:0] d,
                         input logic [1:0] e, input logic r, input logic [7:0] a_r, input logic c);
        wr = w; wa = a_w; wd = d; be = e; rd = r; ra = a_r; clr = c;
        @(negedge clk);
    endtask
    task automatic idle();
        drive(1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 8'h00, 1'b0);
    endtask
    task automatic write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] e);
        drive(1'b1, a, d, e, 1'b0, 8'h00, 1'b0);
    endtask
    task automatic read(input logic [7:0] a);
        drive(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, a, 1'b0);
    endtask

    initial begin
        int cnt;
        wr = 0; wa = 0; wd = 0; be = 0; rd = 0; ra = 0; clr = 0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        cmp1("rst_valid1", b1.o_rd_valid, 1'b0);
        cmp16("rst_data2", b2.o_data_read, 16'h0000);
        cmp1("rst_busy", b1.o_busy, CLR_ON_RST);
        rst_n = 1'b1;
        cnt = 0;
        while (b1.o_busy && cnt < 400) begin cnt++; idle(); end
`ifdef DATA_RAM_CLR_ON_RST_EN
        cmp16("rst_sweep_len", 16'(cnt), 16'(N));
`endif

        write(8'h12, 16'hBEEF, 2'b11);
        read(8'h12);
        cmp1("t1_valid", b1.o_rd_valid, 1'b1);
        cmp16("t1_data", b1.o_data_read, 16'hBEEF);
        idle();
        cmp1("t1_hold_valid", b1.o_rd_valid, 1'b0);
        cmp16("t1_hold_data", b1.o_data_read, 16'hBEEF);

        write(8'h05, 16'h1234, 2'b11);
        write(8'h05, 16'hABCD, 2'b01);
        read(8'h05);
        cmp16("be01_data", b1.o_data_read, 16'h12CD);
        cmp16("model_be01", exp_d1, 16'h12CD);
        write(8'h05, 16'hFFFF, 2'b00);
        read(8'h05);
        cmp16("be00_data", b1.o_data_read, 16'h12CD);

        write(8'h20, 16'h0000, 2'b11);
        drive(1'b1, 8'h20, 16'h5A5A, 2'b10, 1'b1, 8'h20, 1'b0);
        cmp16("coll_data1", b1.o_data_read, 16'h5A00);
        cmp16("model_coll", exp_d1, 16'h5A00);
        idle();
        cmp16("coll_data2", b2.o_data_read, 16'h5A00);

        write(8'h01, 16'h0011, 2'b11);
        write(8'h02, 16'h0022, 2'b11);
        write(8'h03, 16'h0033, 2'b11);
        read(8'h01);
        cmp1("lat2_early", b2.o_rd_valid, 1'b0);
        cmp16("lat1_first", b1.o_data_read, 16'h0011);
        read(8'h02);
        cmp1("lat2_v1", b2.o_rd_valid, 1'b1);
        cmp16("lat2_d1", b2.o_data_read, 16'h0011);
        read(8'h03);
        cmp1("lat2_v2", b2.o_rd_valid, 1'b1);
        cmp16("lat2_d2", b2.o_data_read, 16'h0022);
        idle();
        cmp1("lat2_v3", b2.o_rd_valid, 1'b1);
        cmp16("lat2_d3", b2.o_data_read, 16'h0033);
        idle();
        cmp1("lat2_done", b2.o_rd_valid, 1'b0);

        for (int a = 0; a < 4; a++) write(8'(a), 16'hFFFF, 2'b11);
        drive(1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 8'h00, 1'b1);
        cnt = 0;
        while (b1.o_busy && cnt < 400) begin
            cnt++;
            drive(1'b1, 8'($urandom_range(0, 3)), 16'hFFFF, 2'b11,
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        cmp16("clr_busy_len", 16'(cnt), 16'(N));
        for (int a = 0; a < 4; a++) begin
            read(8'(a));
            cmp16("clr_zero", b1.o_data_read, 16'h0000);
        end

        repeat (800) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                  1'($urandom_range(0, 299) == 0));
        end
        cnt = 0;
        while (b1.o_busy && cnt < 400) begin cnt++; idle(); end
        cmp1("rand_settle", b1.o_busy, 1'b0);

        write(8'hFF, 16'h1234, 2'b11);
`ifdef DATA_RAM_CLR_ON_RST_EN
        rst_n = 1'b0; idle(); idle();
        rst_n = 1'b1;
        repeat (60) idle();
        rst_n = 1'b0; idle(); idle();
        rst_n = 1'b1;
        cnt = 0;
        while (b1.o_busy && cnt < 400) begin cnt++; idle(); end
        cmp16("rst_mid_len", 16'(cnt), 16'(N));
        read(8'hFF);
        cmp16("rst_ff_zero", b1.o_data_read, 16'h0000);
`else
        drive(1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 8'h00, 1'b1);
        repeat (40) idle();
        rst_n = 1'b0; idle();
        rst_n = 1'b1;
        cmp1("abort_busy", b1.o_busy, 1'b0);
        cmp16("abort_data", b1.o_data_read, 16'h0000);
        read(8'hFF);
        cmp16("abort_ff_kept", b1.o_data_read, 16'h1234);
        read(8'h10);
        idle();
`endif
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
